// File: rtl/noc_credit_link.sv
// Credit-terminating link stage: local flit FIFO plus NUM_PIPELINE register stages each way; dequeue-to-send_out is 1+NUM_PIPELINE cycles.
// Upstream is held back by credit_out pulses, downstream by a saturating credit counter; optional sticky link_err under NOC_CREDIT_LINK_ERR_EN.
module noc_credit_link #(
    parameter int FLIT_WIDTH   = 64,
    parameter int DEST_WIDTH   = 6,
    parameter int FIFO_DEPTH   = 2,
    parameter int DOWN_CREDITS = 2,
    parameter int NUM_PIPELINE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in
`ifdef NOC_CREDIT_LINK_ERR_EN
    ,
    output logic                  link_err
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int KW = $clog2(DOWN_CREDITS + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [KW-1:0] MAX_CRED = KW'(DOWN_CREDITS);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    flit_t         r_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [KW-1:0] r_credits;
    logic          r_credit_out;
    logic          r_fwd_vld  [0:NUM_PIPELINE];
    flit_t         r_fwd_flit [0:NUM_PIPELINE];

    logic w_full;
    logic w_deq;
    logic w_enq;
    logic w_cred_ret;

    assign w_full = (r_count == FULL_CNT);
    assign w_deq  = (r_count != '0) && (r_credits != '0);
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign w_enq  = send_in && (!w_full || w_deq);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= '{data: data_in, dest: dest_in, tail: is_tail_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (NUM_PIPELINE == 0) begin : g_cred_direct
            assign w_cred_ret = credit_in;
        end else begin : g_cred_pipe
            logic [NUM_PIPELINE-1:0] r_cred_pipe;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cred_pipe <= '0;
                end else begin
                    r_cred_pipe[0] <= credit_in;
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        r_cred_pipe[i] <= r_cred_pipe[i-1];
                    end
                end
            end
            assign w_cred_ret = r_cred_pipe[NUM_PIPELINE-1];
        end
    endgenerate

    // Credits beyond DOWN_CREDITS can only be spurious, so they are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits    <= MAX_CRED;
            r_credit_out <= 1'b0;
        end else begin
            r_credit_out <= w_deq;
            if (w_deq && !w_cred_ret) begin
                r_credits <= r_credits - 1'b1;
            end else if (w_cred_ret && !w_deq && (r_credits != MAX_CRED)) begin
                r_credits <= r_credits + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_PIPELINE; i++) begin
                r_fwd_vld[i]  <= 1'b0;
                r_fwd_flit[i] <= '0;
            end
        end else begin
            r_fwd_vld[0] <= w_deq;
            if (w_deq) begin
                r_fwd_flit[0] <= r_mem[r_rd_ptr];
            end
            for (int i = 1; i <= NUM_PIPELINE; i++) begin
                r_fwd_vld[i]  <= r_fwd_vld[i-1];
                r_fwd_flit[i] <= r_fwd_flit[i-1];
            end
        end
    end

    assign send_out    = r_fwd_vld[NUM_PIPELINE];
    assign data_out    = r_fwd_flit[NUM_PIPELINE].data;
    assign dest_out    = r_fwd_flit[NUM_PIPELINE].dest;
    assign is_tail_out = r_fwd_flit[NUM_PIPELINE].tail;
    assign credit_out  = r_credit_out;

`ifdef NOC_CREDIT_LINK_ERR_EN
    logic r_link_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_link_err <= 1'b0;
        end else if ((send_in && w_full && !w_deq) || (w_cred_ret && (r_credits == MAX_CRED))) begin
            r_link_err <= 1'b1;
        end
    end
    assign link_err = r_link_err;
`endif

endmodule

// File: tb/tb_noc_credit_link.sv
// Bench for noc_credit_link: vector table plus scoreboard on two instances (P=1/D=2/F=2 and P=2/D=6/F=3).
module tb_noc_credit_link;
    localparam int FW = 64;
    localparam int DW = 6;

    typedef struct packed {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
    } flit_t;

    typedef struct {
        logic          send;
        logic          acc;
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
        logic          cin;
        logic          so;
        logic          co;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [FW-1:0] data_in, data_out, data_in2, data_out2;
    logic [DW-1:0] dest_in, dest_out, dest_in2, dest_out2;
    logic is_tail_in, is_tail_out, send_in, send_out, credit_in, credit_out;
    logic is_tail_in2, is_tail_out2, send_in2, send_out2, credit_in2, credit_out2;
`ifdef NOC_CREDIT_LINK_ERR_EN
    logic link_err, link_err2;
`endif

    noc_credit_link #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FIFO_DEPTH(2), .DOWN_CREDITS(2), .NUM_PIPELINE(1)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
        .send_in(send_in), .credit_out(credit_out), .data_out(data_out), .dest_out(dest_out),
        .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in)
`ifdef NOC_CREDIT_LINK_ERR_EN
        , .link_err(link_err)
`endif
    );

    noc_credit_link #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FIFO_DEPTH(3), .DOWN_CREDITS(6), .NUM_PIPELINE(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(data_in2), .dest_in(dest_in2), .is_tail_in(is_tail_in2),
        .send_in(send_in2), .credit_out(credit_out2), .data_out(data_out2), .dest_out(dest_out2),
        .is_tail_out(is_tail_out2), .send_out(send_out2), .credit_in(credit_in2)
`ifdef NOC_CREDIT_LINK_ERR_EN
        , .link_err(link_err2)
`endif
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    flit_t q1[$];
    flit_t q2[$];
    flit_t m1_got, m1_exp, m2_got, m2_exp;
    int    first2 = -1;
    int    last2 = -1;
    int    so2_cnt = 0;
    int    co2_cnt = 0;
    vec_t  vt[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(logic send, logic acc, logic [FW-1:0] d, logic [DW-1:0] de, logic t,
                               logic cin, logic so, logic co);
        vec_t r;
        r.send = send; r.acc = acc; r.data = d; r.dest = de; r.tail = t;
        r.cin = cin; r.so = so; r.co = co;
        return r;
    endfunction

    // Scoreboards: every emitted flit must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && send_out) begin
            m1_got = {data_out, dest_out, is_tail_out};
            if (q1.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL mon1_unexpected: got flit %0h, expected none (cycle %0d)", m1_got, cyc);
            end else begin
                m1_exp = q1.pop_front();
                chk("mon1_flit", m1_got, m1_exp);
            end
        end
        if (!rst && send_out2) begin
            m2_got = {data_out2, dest_out2, is_tail_out2};
            so2_cnt++;
            if (first2 < 0) first2 = cyc;
            last2 = cyc;
            if (q2.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL mon2_unexpected: got flit %0h, expected none (cycle %0d)", m2_got, cyc);
            end else begin
                m2_exp = q2.pop_front();
                chk("mon2_flit", m2_got, m2_exp);
            end
        end
        if (!rst && credit_out2) co2_cnt++;
    end

    // Downstream of the second instance returns a credit for every flit it sees.
    initial begin
        credit_in2 = 1'b0;
        forever begin
            @(negedge clk);
            credit_in2 = send_out2;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        send_in = 0; credit_in = 0; data_in = '0; dest_in = '0; is_tail_in = 0;
        send_in2 = 0; data_in2 = '0; dest_in2 = '0; is_tail_in2 = 0;

        //           send acc data       dest  tail cin so co
        vt.push_back(v(1, 1, 64'hA5,     6'd5, 1,   0,  0, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  0, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  0, 1));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  1, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   1,  0, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  0, 0));
        vt.push_back(v(1, 1, 64'h1111,   6'd1, 0,   0,  0, 0));
        vt.push_back(v(1, 1, 64'h2222,   6'd2, 0,   0,  0, 0));
        vt.push_back(v(1, 1, 64'h3333,   6'd3, 0,   0,  0, 1));
        vt.push_back(v(1, 1, 64'h4444,   6'd4, 1,   0,  1, 1));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  1, 0));
        vt.push_back(v(1, 0, 64'h5555,   6'd9, 1,   0,  0, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  0, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   1,  0, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  0, 0));
        vt.push_back(v(1, 1, 64'h6666,   6'd6, 0,   0,  0, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  0, 1));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  1, 0));
        vt.push_back(v(0, 0, 64'h0,      6'd0, 0,   0,  0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_send_out", send_out, 0);
        chk("rst_credit_out", credit_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_dest_out", dest_out, 0);
        chk("rst_tail_out", is_tail_out, 0);
        chk("rst_send_out2", send_out2, 0);
        chk("rst_credit_out2", credit_out2, 0);
`ifdef NOC_CREDIT_LINK_ERR_EN
        chk("rst_link_err", link_err, 0);
`endif
        tick();
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            send_in = vt[i].send; data_in = vt[i].data; dest_in = vt[i].dest;
            is_tail_in = vt[i].tail; credit_in = vt[i].cin;
            if (vt[i].send && vt[i].acc) q1.push_back({vt[i].data, vt[i].dest, vt[i].tail});
            @(negedge clk);
            chk($sformatf("vec%0d_send_out", i), send_out, vt[i].so);
            chk($sformatf("vec%0d_credit_out", i), credit_out, vt[i].co);
            tick();
        end
        send_in = 0; credit_in = 0;
`ifdef NOC_CREDIT_LINK_ERR_EN
        chk("drop_link_err", link_err, 1);
`endif

        // Two credits drain the entry kept through the full-FIFO drop and the one refilled during a dequeue.
        credit_in = 1; tick(); tick();
        credit_in = 0;
        repeat (8) tick();
        chk("drain_q1_empty", q1.size(), 0);

        // Reset with three flits in flight and a credit pending.
        send_in = 1; data_in = 64'hAAA1; dest_in = 6'd10; is_tail_in = 0; q1.push_back({data_in, dest_in, is_tail_in}); tick();
        data_in = 64'hAAA2; dest_in = 6'd11; q1.push_back({data_in, dest_in, is_tail_in}); tick();
        send_in = 0; credit_in = 1; tick();
        credit_in = 0; tick();
        send_in = 1; data_in = 64'hAAA3; dest_in = 6'd12; is_tail_in = 1; q1.push_back({data_in, dest_in, is_tail_in}); tick();
        send_in = 0; rst = 1; tick();
        q1.delete();
        rst = 0;
        @(negedge clk);
        chk("midrst_send_out", send_out, 0);
        chk("midrst_credit_out", credit_out, 0);
`ifdef NOC_CREDIT_LINK_ERR_EN
        chk("midrst_link_err_clr", link_err, 0);
`endif
        credit_in = 1; tick();

        // Spurious credit above is ignored: only two of the three new flits may leave.
        credit_in = 0;
        send_in = 1; is_tail_in = 0;
        for (int i = 0; i < 3; i++) begin
            data_in = 64'hB000 + 64'(i); dest_in = 6'(20 + i);
            q1.push_back({data_in, dest_in, is_tail_in});
            tick();
        end
        send_in = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_send_out_c%0d", k + 3), send_out, (k < 2) ? 1'b1 : 1'b0);
            tick();
        end
        chk("sat_third_flit_held", q1.size(), 1);
`ifdef NOC_CREDIT_LINK_ERR_EN
        chk("sat_link_err", link_err, 1);
`endif

        // 100-flit packet through the deeper instance with credits echoed back.
        for (int i = 0; i < 100; i++) begin
            send_in2 = 1; data_in2 = {32'hC0DE0000, 32'(i)}; dest_in2 = 6'(i % 64);
            is_tail_in2 = (i == 99);
            q2.push_back({data_in2, dest_in2, is_tail_in2});
            tick();
        end
        send_in2 = 0; is_tail_in2 = 0;
        repeat (30) tick();
        chk("stream_flit_count", so2_cnt, 100);
        chk("stream_no_bubbles", last2 - first2, 99);
        chk("stream_credit_out_count", co2_cnt, 100);
        chk("stream_q2_empty", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
